// File: rtl/cpu_pkg.sv
// Shared ALU controller codes, EX-stage FSM states and datapath width default.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;

   localparam logic [3:0] CTRL_AND = 4'd0;
   localparam logic [3:0] CTRL_OR  = 4'd1;
   localparam logic [3:0] CTRL_ADD = 4'd2;
   localparam logic [3:0] CTRL_MUL = 4'd3;
   localparam logic [3:0] CTRL_SUB = 4'd6;
   localparam logic [3:0] CTRL_SLT = 4'd7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: retires MUL_STEP multiplier bits per cycle.
module mul_iter #(
   parameter int DATA_W   = 32,
   parameter int MUL_STEP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              last,
   output logic [DATA_W-1:0] prod
);

   localparam int K  = DATA_W / MUL_STEP;
   localparam int CW = $clog2(K + 1);

   logic [DATA_W-1:0] a_q, b_q, acc_q, partial;
   logic [CW-1:0]     cnt_q;

   always_comb begin
      partial = '0;
      for (int unsigned j = 0; j < MUL_STEP; j++) begin
         if (b_q[j]) partial = partial + (a_q << j);
      end
   end

   // cnt_q == 0 means idle; the product is taken combinationally on the final step
   assign last = (cnt_q == CW'(1));
   assign prod = acc_q + partial;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         a_q   <= op_a;
         b_q   <= op_b;
         acc_q <= '0;
         cnt_q <= CW'(K);
      end else if (cnt_q != '0) begin
         if (abort || last) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q - CW'(1);
         end
         acc_q <= prod;
         a_q   <= a_q << MUL_STEP;
         b_q   <= b_q >> MUL_STEP;
      end
   end

endmodule

// File: rtl/ex_alu_mc.sv
// EX-stage ALU with multi-cycle multiply and upstream stall.
// Define ALU_OVF_EN to add the registered signed-overflow output ovf_o.
module ex_alu_mc
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MUL_STEP = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [3:0]        ctrl_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic              ready_o,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
`ifdef ALU_OVF_EN
   ,
   output logic              ovf_o
`endif
);

   state_t            state;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] mul_prod;
   logic              mul_last;
   logic              accept;
   logic              is_mul;

   assign is_mul  = (ctrl_i == CTRL_MUL);
   assign accept  = (state == IDLE) && valid_i && !flush_i;
   assign ready_o = (state == IDLE);
   assign stall_o = (state == RUN) || (accept && is_mul);

   always_comb begin
      alu_res = '0;
      case (ctrl_i)
         CTRL_AND: alu_res = src1_i & src2_i;
         CTRL_OR:  alu_res = src1_i | src2_i;
         CTRL_ADD: alu_res = src1_i + src2_i;
         CTRL_SUB: alu_res = src1_i - src2_i;
         CTRL_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
         default:  alu_res = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   logic alu_ovf;
   always_comb begin
      alu_ovf = 1'b0;
      if (ctrl_i == CTRL_ADD)
         alu_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) && (alu_res[DATA_W-1] != src1_i[DATA_W-1]);
      else if (ctrl_i == CTRL_SUB)
         alu_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) && (alu_res[DATA_W-1] != src1_i[DATA_W-1]);
   end
`endif

   mul_iter #(
      .DATA_W   (DATA_W),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk   (clk_i),
      .rst_n (rst_i),
      .start (accept && is_mul),
      .abort ((state == RUN) && flush_i),
      .op_a  (src1_i),
      .op_b  (src2_i),
      .last  (mul_last),
      .prod  (mul_prod)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         result_o <= '0;
         zero_o   <= 1'b0;
         done_o   <= 1'b0;
`ifdef ALU_OVF_EN
         ovf_o    <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state <= RUN;
                  end else begin
                     result_o <= alu_res;
                     zero_o   <= (alu_res == '0);
                     done_o   <= 1'b1;
`ifdef ALU_OVF_EN
                     ovf_o    <= alu_ovf;
`endif
                  end
               end
            end
            RUN: begin
               // a flush on the final step still wins over completion
               if (flush_i) begin
                  state <= IDLE;
               end else if (mul_last) begin
                  state    <= IDLE;
                  result_o <= mul_prod;
                  zero_o   <= (mul_prod == '0);
                  done_o   <= 1'b1;
`ifdef ALU_OVF_EN
                  ovf_o    <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu_mc.sv
// Self-checking bench for ex_alu_mc: vector table, corner sequences, randomized ops vs reference model.
module tb_ex_alu_mc;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        flush;
   logic [3:0]  ctrl;
   logic [31:0] src1, src2;
   logic        ready_o, stall_o, done_o, zero_o;
   logic [31:0] result_o;
   logic        ready4, stall4, done4, zero4;
   logic [31:0] result4;
`ifdef ALU_OVF_EN
   logic        ovf_o, ovf4;
`endif

   int errors = 0;
   int checks = 0;

   ex_alu_mc #(.DATA_W(32), .MUL_STEP(1)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .ctrl_i(ctrl),
      .src1_i(src1), .src2_i(src2), .ready_o(ready_o), .stall_o(stall_o),
      .done_o(done_o), .result_o(result_o), .zero_o(zero_o)
`ifdef ALU_OVF_EN
      , .ovf_o(ovf_o)
`endif
   );

   ex_alu_mc #(.DATA_W(32), .MUL_STEP(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .ctrl_i(ctrl),
      .src1_i(src1), .src2_i(src2), .ready_o(ready4), .stall_o(stall4),
      .done_o(done4), .result_o(result4), .zero_o(zero4)
`ifdef ALU_OVF_EN
      , .ovf_o(ovf4)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference model: results straight from the arithmetic definition of each code
   function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      case (c)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd6: return a - b;
         4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3: begin
            p = longint'(a) * longint'(b);
            return p[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      longint s;
      if (c == 4'd2)      s = longint'($signed(a)) + longint'($signed(b));
      else if (c == 4'd6) s = longint'($signed(a)) - longint'($signed(b));
      else return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // issue one op in cycle N and follow it to its done_o pulse
   task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input int elat, input bit noise);
      int lat;
      int stall_bad;
      valid = 1'b1; ctrl = c; src1 = a; src2 = b; flush = 1'b0;
      #1;
      chk({nm, "_stall_n"}, stall_o, (c == 4'd3));
      tick();
      valid = 1'b0;
      lat = 1;
      stall_bad = 0;
      while (!done_o && lat < 200) begin
         if (stall_o !== 1'b1 || ready_o !== 1'b0) stall_bad++;
         if (noise) begin
            valid = 1'b1; ctrl = 4'd2; src1 = $urandom; src2 = $urandom;
         end
         tick();
         lat++;
      end
      valid = 1'b0;
      #1;
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_result"}, result_o, er);
      chk({nm, "_zero"}, zero_o, ez);
      chk({nm, "_stall_run"}, stall_bad, 0);
      chk({nm, "_idle_at_done"}, {stall_o, ready_o}, 2'b01);
`ifdef ALU_OVF_EN
      chk({nm, "_ovf"}, ovf_o, ref_ovf(c, a, b));
`endif
      tick();
      chk({nm, "_done_single"}, done_o, 1'b0);
   endtask

   typedef struct {
      string       nm;
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      int          lat;
      bit          noise;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int t;
      int dcount;
      logic [3:0] codes[9];
      logic [3:0] c;
      logic [31:0] a, b;

      tbl[0] = '{"add_ovf",  4'd2, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1,  1'b0};
      tbl[1] = '{"sub_zero", 4'd6, 32'h5,        32'h5,        32'h0,        1'b1, 1,  1'b0};
      tbl[2] = '{"slt_neg",  4'd7, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1,  1'b0};
      tbl[3] = '{"and",      4'd0, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1,  1'b0};
      tbl[4] = '{"mul_neg",  4'd3, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 1'b1};
      tbl[5] = '{"or",       4'd1, 32'h12,       32'h300,      32'h312,      1'b0, 1,  1'b0};
      tbl[6] = '{"bad_code", 4'd4, 32'h5,        32'h6,        32'h0,        1'b1, 1,  1'b0};
      tbl[7] = '{"slt_pos",  4'd7, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1, 1,  1'b0};
      tbl[8] = '{"sub_wrap", 4'd6, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1,  1'b0};
      tbl[9] = '{"mul_zero", 4'd3, 32'h0,        32'h5,        32'h0,        1'b1, 33, 1'b0};

      rst = 1'b0; valid = 1'b0; flush = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
      tick();
      chk("reset_outputs", {result_o, zero_o, done_o, ready_o, stall_o}, {32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      tick();
      rst = 1'b1;

      for (int i = 0; i < 10; i++)
         run_op(tbl[i].nm, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z, tbl[i].lat, tbl[i].noise);

      // flush in the middle of a multiply
      run_op("pre_flush", 4'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1, 1'b0);
      valid = 1'b1; ctrl = 4'd3; src1 = 32'd9; src2 = 32'd9;
      tick();
      valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_state", {ready_o, done_o, stall_o}, 3'b100);
      chk("flush_result_hold", result_o, 32'd7);
      dcount = 0;
      repeat (40) begin
         if (done_o) dcount++;
         tick();
      end
      chk("flush_no_done", dcount, 0);
      chk("flush_result_later", result_o, 32'd7);

      // reset during a multiply
      valid = 1'b1; ctrl = 4'd3; src1 = 32'd5; src2 = 32'd5;
      tick();
      valid = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_mul", {result_o, zero_o, done_o, ready_o, stall_o}, {32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      rst = 1'b1;
      run_op("add_after_rst", 4'd2, 32'd2, 32'd2, 32'd4, 1'b0, 1, 1'b0);

      // back-to-back ADD, MUL, OR with valid held throughout
      valid = 1'b1; ctrl = 4'd2; src1 = 32'd10; src2 = 32'd20;
      tick();
      t = 1;
      chk("b2b_add", {done_o, result_o}, {1'b1, 32'd30});
      ctrl = 4'd3; src1 = 32'd6; src2 = 32'd7;
      #1;
      chk("b2b_mul_stall", stall_o, 1'b1);
      tick();
      t++;
      while (!done_o && t < 200) begin
         tick();
         t++;
      end
      chk("b2b_mul_cycle", t, 34);
      chk("b2b_mul", result_o, 32'd42);
      ctrl = 4'd1; src1 = 32'hF0; src2 = 32'h0F;
      tick();
      valid = 1'b0;
      chk("b2b_or", {done_o, result_o}, {1'b1, 32'hFF});
      tick();
      chk("b2b_quiet", done_o, 1'b0);

      // randomized ops against the reference model
      codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd4, 4'd5, 4'd15};
      for (int i = 0; i < 40; i++) begin
         c = codes[$urandom_range(0, 8)];
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            a = a & 32'hF;
            b = (c == 4'd6) ? a : (b & 32'hF);
         end
         run_op("rand", c, a, b, ref_res(c, a, b), (ref_res(c, a, b) == 32'd0),
                (c == 4'd3) ? 33 : 1, 1'($urandom_range(0, 1)));
      end

      // MUL_STEP=4 instance: K=8, done in N+9
      rst = 1'b0;
      tick();
      rst = 1'b1;
      valid = 1'b1; ctrl = 4'd3; src1 = 32'd7; src2 = 32'hFFFFFFFD;
      tick();
      valid = 1'b0;
      t = 1;
      while (!done4 && t < 100) begin
         tick();
         t++;
      end
      chk("step4_latency", t, 9);
      chk("step4_result", {result4, zero4}, {32'hFFFFFFEB, 1'b0});
      tick();
      chk("step4_done_single", {done4, ready4, stall4}, 3'b010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
